// File: rtl/exe_mul_unit.sv
// Iterative shift-add multiplier (MUL/MLA) for the EXE stage with N/Z flags and pipeline stall.
// Optional macro MUL_EARLY_TERMINATE_EN: finish as soon as the remaining multiplier bits are zero.
module exe_mul_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_n,
  output logic             result_z
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One partial-product term per multiplier bit retired this cycle.
  logic [WIDTH-1:0] pp_terms [BITS_PER_CYCLE];
  logic [WIDTH-1:0] pp_sum;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] mplier_shift;
  logic             last_step;

  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp_terms[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp_sum = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      pp_sum = pp_sum + pp_terms[b];
    end
  end

  assign acc_sum      = acc_q + pp_sum;
  assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

`ifdef MUL_EARLY_TERMINATE_EN
  assign last_step = (cnt_q == CW'(1)) || (mplier_shift == '0);
`else
  assign last_step = (cnt_q == CW'(1));
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            mcand_d  = val1;
            mplier_d = val2;
            acc_d    = accumulate ? acc_in : '0;
            cnt_d    = CW'(N);
            state_d  = S_RUN;
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_RUN: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_shift;
          cnt_d    = cnt_q - CW'(1);
          if (last_step) begin
            result_d = acc_sum;
            state_d  = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // Combinational so the ID_EXE register is frozen in the very cycle start is accepted.
  assign stall    = ~flush & ((state_q == S_RUN) |
                              (((state_q == S_IDLE) | (state_q == S_DONE)) & start));
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE) & ~flush;
  assign result   = result_q;
  assign result_n = result_q[WIDTH-1];
  assign result_z = (result_q == '0);

endmodule

// File: tb/tb_exe_mul_unit.sv
// Directed self-checking bench for exe_mul_unit (WIDTH=32, BITS_PER_CYCLE=1).
module tb_exe_mul_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic [31:0] val1 = '0;
  logic [31:0] val2 = '0;
  logic [31:0] acc_in = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done, result_n, result_z;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  exe_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
    .val1(val1), .val2(val2), .acc_in(acc_in), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result),
    .result_n(result_n), .result_z(result_z)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from accepting start (T) to the done pulse.
  function automatic int exp_lat(input logic [31:0] v2);
`ifdef MUL_EARLY_TERMINATE_EN
    int msb = -1;
    for (int i = 0; i < 32; i++) if (v2[i]) msb = i;
    return (msb < 0) ? 2 : msb + 2;
`else
    return 33;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input string tag, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] ai, input logic acc_en, input logic [31:0] exp_res);
    int n;
    int stall_bad;
    start = 1'b1; val1 = v1; val2 = v2; acc_in = ai; accumulate = acc_en;
    #1;
    check({tag, " stall_at_T"}, 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    n = 1;
    stall_bad = 0;
    while (!done && n < 200) begin
      if (!stall) stall_bad++;
      tick();
      n++;
    end
    $display("%s: val1=%0h val2=%0h acc_in=%0h mla=%0d -> result=%0h after %0d cycles",
             tag, v1, v2, ai, acc_en, result, n);
    check({tag, " latency"}, 32'(n), 32'(exp_lat(v2)));
    check({tag, " stall_during_run"}, 32'(stall_bad), 32'd0);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " stall_in_done"}, 32'(stall), 32'd0);
    check({tag, " result"}, result, exp_res);
    check({tag, " result_n"}, 32'(result_n), 32'(exp_res[31]));
    check({tag, " result_z"}, 32'(result_z), 32'(exp_res == 32'd0));
    tick();
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int m;
    int done_seen;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    $display("reset: result=%0h z=%0d n=%0d stall=%0d busy=%0d done=%0d",
             result, result_z, result_n, stall, busy, done);
    check("reset result", result, 32'd0);
    check("reset result_z", 32'(result_z), 32'd1);
    check("reset result_n", 32'(result_n), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    tick();

    run_mul("mul_6x7", 32'd6, 32'd7, 32'd0, 1'b0, 32'd42);
    run_mul("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h0000_0001);
    run_mul("mul_msb", 32'h8000_0000, 32'd1, 32'd0, 1'b0, 32'h8000_0000);
    run_mul("mla_3x4p10", 32'd3, 32'd4, 32'd10, 1'b1, 32'd22);

    // Flush at T+10 aborts the operation and leaves the previous result intact
    start = 1'b1; val1 = 32'd123; val2 = 32'hFFFF_FFFF; accumulate = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    #1;
    check("flush stall_same_cycle", 32'(stall), 32'd0);
    check("flush no_done", 32'(done), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush busy_after", 32'(busy), 32'd0);
    check("flush stall_after", 32'(stall), 32'd0);
    check("flush result_kept", result, 32'd22);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      tick();
    end
    $display("flush: result=%0h busy=%0d done_pulses=%0d", result, busy, done_seen);
    check("flush done_never", 32'(done_seen), 32'd0);

    run_mul("mul_0x9", 32'd0, 32'd9, 32'd0, 1'b0, 32'd0);
    run_mul("mul_11x5", 32'd11, 32'd5, 32'd0, 1'b0, 32'd55);
    run_mul("mla_x0p77", 32'd99, 32'd0, 32'd77, 1'b1, 32'd77);

    // Back-to-back: start held in the DONE cycle; a start pulse during RUN is ignored
    start = 1'b1; val1 = 32'd2; val2 = 32'd3; accumulate = 1'b0;
    tick();
    start = 1'b0;
    m = 1;
    while (!done && m < 200) begin tick(); m++; end
    check("b2b first_latency", 32'(m), 32'(exp_lat(32'd3)));
    check("b2b first_done", 32'(done), 32'd1);
    check("b2b first_result", result, 32'd6);
    start = 1'b1; val1 = 32'd5; val2 = 32'd5;
    #1;
    check("b2b stall_in_done_with_start", 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    m = 1;
    while (!done && m < 200) begin
      if (m == 2) begin start = 1'b1; val1 = 32'd9; val2 = 32'd9; end
      if (m == 3) start = 1'b0;
      tick();
      m++;
    end
    $display("b2b: second result=%0h after %0d cycles", result, m);
    check("b2b second_latency", 32'(m), 32'(exp_lat(32'd5)));
    check("b2b second_done", 32'(done), 32'd1);
    check("b2b second_result", result, 32'd25);
    tick();
    check("b2b start_in_run_ignored", 32'(busy), 32'd0);

    // Reset mid-operation
    start = 1'b1; val1 = 32'd7; val2 = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    $display("mid_reset: busy=%0d stall=%0d result=%0h", busy, stall, result);
    check("mid_reset busy", 32'(busy), 32'd0);
    check("mid_reset stall", 32'(stall), 32'd0);
    check("mid_reset result", result, 32'd0);
    check("mid_reset result_z", 32'(result_z), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mul_unit.md
Name: exe_mul_unit

Overview:
- Iterative shift-add multiplier in the EXE stage, downstream of the Val2 generator.
- Consumes Val1 (Rn) and the generated Val2 for MUL/MLA instructions.
- Produces a 32-bit product (optionally accumulated) plus N/Z flags.
- Holds the pipeline via a stall output until the product is ready.

Parameters:
- WIDTH, 32: operand and result width.
- BITS_PER_CYCLE, 1: multiplier bits retired per RUN cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a multiply; sampled in IDLE or DONE
- accumulate  in  1  MLA select; sampled with start
- val1  in  WIDTH  multiplicand (Rn value)
- val2  in  WIDTH  multiplier (Val2 generator output)
- acc_in  in  WIDTH  accumulate operand (Rd value); sampled with start
- flush  in  1  synchronous abort (branch taken / pipeline flush)
- stall  out  1  freeze request to IF/ID/ID_EXE registers
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  product, held until the next completion
- result_n  out  1  result[WIDTH-1]
- result_z  out  1  result == 0

Behaviour:
- States: IDLE, RUN, DONE. Reset: state=IDLE; result=0; all internal registers 0; stall=0, busy=0, done=0; result_z=1, result_n=0.
- IDLE/DONE with start=1, flush=0:
  - mcand <= val1; mplier <= val2; acc <= (accumulate ? acc_in : 0); cnt <= WIDTH/BITS_PER_CYCLE.
  - Next state RUN.
- RUN, each cycle:
  - acc <= acc + mcand * mplier[BITS_PER_CYCLE-1:0], truncated to WIDTH.
  - mcand <= mcand << BITS_PER_CYCLE; mplier <= mplier >> BITS_PER_CYCLE; cnt <= cnt-1.
  - start is ignored in RUN.
- Last RUN cycle (cnt==1): result <= the updated acc value; next state DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or RUN if start=1 (back-to-back).
- Arithmetic is unsigned modulo 2^WIDTH; the low 32 bits equal the signed product. No carry/overflow flags.
- stall = (state==RUN) | ((state==IDLE | state==DONE) & start & ~flush). It is combinational so the ID_EXE register holds operands from the accepting cycle.
- Latency: start accepted at cycle T gives stall high T..T+N and done high at T+N+1, where N = WIDTH/BITS_PER_CYCLE. stall is low in the DONE cycle so EXE_MEM captures result.
- flush takes priority over start and RUN in any state:
  - Next state IDLE; result unchanged; done not asserted; stall low in the same cycle.
- rst mid-operation: immediate return to reset values at the next edge.
- result_n and result_z are combinational from the result register.

Optional Feature:
- Macro MUL_EARLY_TERMINATE_EN.
- Defined:
  - In RUN, the cycle whose shifted mplier equals 0 is the last step (result loaded, go to DONE), as is cnt==1.
  - Latency becomes ceil(msb_index(val2)+1 / BITS_PER_CYCLE) RUN cycles, with a minimum of 1.
  - val2=0 gives done at T+2.
- Undefined: fixed N RUN cycles regardless of operand values.

Test Plan:
- BITS_PER_CYCLE=1, start with val1=6, val2=7, accumulate=0 at T -> stall high T..T+32; done pulses at T+33; result=42, result_n=0, result_z=0.
- val1=0xFFFFFFFF, val2=0xFFFFFFFF -> result=0x00000001; then val1=0x80000000, val2=1 -> result=0x80000000, result_n=1.
- MLA: val1=3, val2=4, acc_in=10, accumulate=1 -> result=22. Then val1=0, val2=9, accumulate=0 -> result=0, result_z=1.
- Flush: start at T, flush=1 at T+10 -> state IDLE at T+11; stall low at T+10; done never pulses; result keeps its previous value (22).
- Back-to-back: start held high in the DONE cycle with val1=5, val2=5 -> first result visible with done; second done exactly N+1 cycles later with result=25. Also: start asserted during RUN is ignored.
- MUL_EARLY_TERMINATE_EN defined, BITS_PER_CYCLE=1:
  - val2=5 at T -> done at T+4, result=5*val1.
  - val2=0 -> done at T+2, result=acc value.
  - Undefined: both cases -> done at T+33.
